load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 16 +
 rtl/lsu_watchdog.sv | 31 +++
 rtl/load_store_unit.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - state encoding and default sizing for the load/store unit
package lsu_pkg;

  localparam int unsigned LSU_ADDR_W         = 8;
  localparam int unsigned LSU_DATA_W         = 32;
  localparam int unsigned LSU_TIMEOUT_CYCLES = 16;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT,
    TURN,
    SETTLE
  } lsu_state_e;

endpackage

// File: rtl/lsu_watchdog.sv
// rtl/lsu_watchdog.sv - cycle counter that flags expiry after LIMIT enabled clocks
module lsu_watchdog
  import lsu_pkg::*;
#(
  parameter int unsigned LIMIT = LSU_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] count;

  assign expire = enable && (count == CNT_W'(LIMIT - 1));

  // Saturates at expiry so a stalled owner cannot wrap the counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expire) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store bus master with ARM/WAIT/TURN/SETTLE handshake
// Optional response watchdog enabled by defining LSU_TIMEOUT_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W         = LSU_ADDR_W,
  parameter int unsigned DATA_W         = LSU_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = LSU_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              reqWrite,
  input  logic [ADDR_W-1:0] reqAddr,
  input  logic [DATA_W-1:0] reqWdata,
  output logic              busy,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              err,
  output logic              chipSel,
  output logic [ADDR_W-1:0] addr,
  inout  wire  [DATA_W-1:0] dat,
  output logic              write,
  input  logic              ready
);

  lsu_state_e        state, state_d;
  logic              chip_sel_q, chip_sel_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              timeout_hit;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

`ifdef LSU_TIMEOUT_EN
  logic wd_clear, wd_enable, wd_expire, err_q;

  // Counting only in the two ready-wait states clears it on every entry to them
  assign wd_enable   = (state == WAIT) || (state == SETTLE);
  assign wd_clear    = !wd_enable;
  assign timeout_hit = wd_expire && !ready;

  lsu_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expire (wd_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= timeout_hit;
    end
  end

  assign err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      chip_sel_q <= 1'b0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      state      <= state_d;
      chip_sel_q <= chip_sel_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
    end
  end

  always_comb begin
    state_d    = state;
    chip_sel_d = chip_sel_q;
    write_d    = write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    rvalid_d   = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          addr_d     = reqAddr;
          write_d    = reqWrite;
          wdata_d    = reqWdata;
          chip_sel_d = 1'b1;
          state_d    = ARM;
        end
      end
      // ready seen here still belongs to the previous access
      ARM: state_d = WAIT;
      WAIT: begin
        if (ready) begin
          if (!write_q) begin
            rdata_d  = dat;
            rvalid_d = 1'b1;
          end
          chip_sel_d = 1'b0;
          state_d    = TURN;
        end else if (timeout_hit) begin
          chip_sel_d = 1'b0;
          state_d    = IDLE;
        end
      end
      TURN: state_d = SETTLE;
      // Swallows the responder's completion of the access it re-issued on our exit edge
      SETTLE: begin
        if (ready || timeout_hit) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state != IDLE);
  assign chipSel = chip_sel_q;
  assign write   = write_q;
  assign addr    = addr_q;
  assign rdata   = rdata_q;
  assign rvalid  = rvalid_q;
  assign dat     = (chip_sel_q && write_q) ? wdata_q : {DATA_W{1'bz}};

endmodule
